// File: rtl/std_ram_sp_arb.sv
// Write/read request arbiter in front of a single-port RAM, with latency tracking and a credit-protected response FIFO.
// Optional macro STD_RAM_SP_ARB_STATS_EN adds 16-bit saturating grant/stall counters. Supports RAM_REG of 0 or 1.
module std_ram_sp_arb #(
  parameter int DW        = 32,
  parameter int DEPTH     = 32,
  parameter int AW        = $clog2(DEPTH),
  parameter int RAM_REG   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [DW-1:0] wr_mask,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          ram_wr_en,
  output logic          ram_rd_en,
  output logic [DW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
`ifdef STD_RAM_SP_ARB_STATS_EN
  ,
  output logic [15:0]   stat_wr,
  output logic [15:0]   stat_rd,
  output logic [15:0]   stat_stall
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  prio_e         prio_q, prio_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] fifo_mem [RSP_DEPTH];

  logic       wr_grant, rd_grant, rd_eligible;
  logic       push, pop;
  logic [1:0] inflight;

  // Read data arrives at capture time; with a registered RAM that is one cycle after the grant.
  if (RAM_REG != 0) begin : g_reg_out
    logic pipe_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) pipe_q <= 1'b0;
      else       pipe_q <= rd_grant;
    end
    assign push     = pipe_q;
    assign inflight = {1'b0, pipe_q};
  end else begin : g_comb_out
    assign push     = rd_grant;
    assign inflight = 2'd0;
  end

  assign rd_eligible = rd_valid && ((int'(count_q) + int'(inflight)) < RSP_DEPTH);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (!reset) begin
      if (wr_valid && rd_eligible) begin
        if (prio_q == PRIO_WR) wr_grant = 1'b1;
        else                   rd_grant = 1'b1;
      end else if (wr_valid) begin
        wr_grant = 1'b1;
      end else if (rd_eligible) begin
        rd_grant = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    addr_d = addr_q;
    if (wr_grant) begin
      prio_d = PRIO_RD;
      addr_d = wr_addr;
    end else if (rd_grant) begin
      prio_d = PRIO_WR;
      addr_d = rd_addr;
    end
  end

  assign wr_ready  = wr_grant;
  assign rd_ready  = rd_grant;
  assign ram_wr_en = wr_grant;
  assign ram_rd_en = rd_grant;
  assign ram_wem   = wr_grant ? wr_mask : '0;
  assign ram_addr  = addr_d;
  assign ram_din   = wr_data;

  assign rsp_valid = (count_q != '0);
  assign rsp_data  = fifo_mem[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = rsp_valid || (inflight != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q   <= PRIO_WR;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= ram_dout;
  end

`ifdef STD_RAM_SP_ARB_STATS_EN
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_wr_d    = stat_wr_q;
    stat_rd_d    = stat_rd_q;
    stat_stall_d = stat_stall_q;
    if (wr_grant && (stat_wr_q != 16'hFFFF))                  stat_wr_d    = stat_wr_q + 16'd1;
    if (rd_grant && (stat_rd_q != 16'hFFFF))                  stat_rd_d    = stat_rd_q + 16'd1;
    if (rd_valid && !rd_ready && (stat_stall_q != 16'hFFFF))  stat_stall_d = stat_stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_wr_q    <= stat_wr_d;
      stat_rd_q    <= stat_rd_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_wr    = stat_wr_q;
  assign stat_rd    = stat_rd_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_std_ram_sp_arb.sv
// Directed bench for std_ram_sp_arb: instance u_a with a registered RAM model, u_z with a combinational one.
module tb_std_ram_sp_arb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A (RAM_REG=1)
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] wr_addr, rd_addr, ram_addr;
  logic [DW-1:0] wr_data, wr_mask, rsp_data, ram_wem, ram_din, ram_dout;
  logic          ram_wr_en, ram_rd_en, busy;
  // Instance Z (RAM_REG=0)
  logic          z_wr_valid, z_wr_ready, z_rd_valid, z_rd_ready, z_rsp_valid, z_rsp_ready;
  logic [AW-1:0] z_wr_addr, z_rd_addr, z_ram_addr;
  logic [DW-1:0] z_wr_data, z_wr_mask, z_rsp_data, z_ram_wem, z_ram_din, z_ram_dout;
  logic          z_ram_wr_en, z_ram_rd_en, z_busy;
`ifdef STD_RAM_SP_ARB_STATS_EN
  logic [15:0] a_stat_wr, a_stat_rd, a_stat_stall, z_stat_wr, z_stat_rd, z_stat_stall;
`endif

  std_ram_sp_arb #(.DW(DW), .DEPTH(32), .RAM_REG(1), .RSP_DEPTH(2)) u_a (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
`ifdef STD_RAM_SP_ARB_STATS_EN
    , .stat_wr(a_stat_wr), .stat_rd(a_stat_rd), .stat_stall(a_stat_stall)
`endif
  );

  std_ram_sp_arb #(.DW(DW), .DEPTH(32), .RAM_REG(0), .RSP_DEPTH(2)) u_z (
    .clk(clk), .reset(reset),
    .wr_valid(z_wr_valid), .wr_ready(z_wr_ready), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .wr_mask(z_wr_mask),
    .rd_valid(z_rd_valid), .rd_ready(z_rd_ready), .rd_addr(z_rd_addr),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data),
    .ram_wr_en(z_ram_wr_en), .ram_rd_en(z_ram_rd_en), .ram_wem(z_ram_wem), .ram_addr(z_ram_addr),
    .ram_din(z_ram_din), .ram_dout(z_ram_dout), .busy(z_busy)
`ifdef STD_RAM_SP_ARB_STATS_EN
    , .stat_wr(z_stat_wr), .stat_rd(z_stat_rd), .stat_stall(z_stat_stall)
`endif
  );

  // RAM models: bit-masked write; registered read for A, combinational read for Z.
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_z [32];

  always @(posedge clk) begin
    if (ram_wr_en) mem_a[ram_addr] <= (mem_a[ram_addr] & ~ram_wem) | (ram_din & ram_wem);
    if (ram_rd_en) ram_dout <= mem_a[ram_addr];
    if (z_ram_wr_en) mem_z[z_ram_addr] <= (mem_z[z_ram_addr] & ~z_ram_wem) | (z_ram_din & z_ram_wem);
  end
  assign z_ram_dout = mem_z[z_ram_addr];

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    #1;
    while (!wr_ready && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL write_a_timeout addr=%0d got wr_ready=%b exp=1", a, wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic read_a(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n;
    n = 0;
    rd_valid = 1'b1; rd_addr = a;
    #1;
    while (!rd_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    rd_valid = 1'b0;
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL read_a_timeout addr=%0d got rsp_valid=%b exp=1", a, rsp_valid); end
    d = rsp_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_valid = 1'b1; rd_valid = 1'b1; z_wr_valid = 1'b1; z_rd_valid = 1'b1;
    #1;
    total++; if (wr_ready   !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    total++; if (rd_ready   !== 1'b0) begin bad++; $display("FAIL reset_rd_ready got=%b exp=0", rd_ready); end
    total++; if (ram_wr_en  !== 1'b0) begin bad++; $display("FAIL reset_ram_wr_en got=%b exp=0", ram_wr_en); end
    total++; if (ram_rd_en  !== 1'b0) begin bad++; $display("FAIL reset_ram_rd_en got=%b exp=0", ram_rd_en); end
    total++; if (rsp_valid  !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (busy       !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (z_wr_ready !== 1'b0) begin bad++; $display("FAIL reset_z_wr_ready got=%b exp=0", z_wr_ready); end
    wr_valid = 1'b0; rd_valid = 1'b0; z_wr_valid = 1'b0; z_rd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_mask = 32'hFFFFFFFF;
    #1;
    total++; if (wr_ready  !== 1'b1) begin bad++; $display("FAIL wr_grant_ready got=%b exp=1", wr_ready); end
    total++; if (ram_wr_en !== 1'b1 || ram_rd_en !== 1'b0) begin bad++; $display("FAIL wr_grant_en got=%b%b exp=10", ram_wr_en, ram_rd_en); end
    total++; if (ram_addr  !== 5'd5) begin bad++; $display("FAIL wr_grant_addr got=%0d exp=5", ram_addr); end
    total++; if (ram_wem   !== 32'hFFFFFFFF || ram_din !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_grant_wem_din got=%h/%h exp=ffffffff/deadbeef", ram_wem, ram_din); end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd5;
    #1;
    total++; if (rd_ready !== 1'b1 || ram_rd_en !== 1'b1 || ram_wr_en !== 1'b0) begin bad++; $display("FAIL rd_grant got rdy=%b rd_en=%b wr_en=%b exp=1/1/0", rd_ready, ram_rd_en, ram_wr_en); end
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rd_lat1 got rsp_valid=%b busy=%b exp=0/1", rsp_valid, busy); end
    total++; if (ram_addr !== 5'd5 || ram_wem !== 32'h0 || ram_rd_en !== 1'b0) begin bad++; $display("FAIL idle_hold got addr=%0d wem=%h rd_en=%b exp=5/0/0", ram_addr, ram_wem, ram_rd_en); end
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_lat2_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_lat2_data got=%h exp=deadbeef", rsp_data); end
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_drained got rsp_valid=%b busy=%b exp=0/0", rsp_valid, busy); end
    @(negedge clk);
  endtask

  task automatic test_alternate();
    logic exp_w;
    apply_reset();
    wr_valid = 1'b1; wr_addr = 5'd10; wr_mask = 32'hFFFFFFFF; rd_valid = 1'b1; rd_addr = 5'd11;
    for (int i = 0; i < 6; i++) begin
      wr_data = 32'h100 + i;
      #1;
      exp_w = (i % 2 == 0);
      total++;
      if (wr_ready !== exp_w || rd_ready !== !exp_w || (ram_wr_en && ram_rd_en)) begin
        bad++; $display("FAIL alternate_cycle%0d got w=%b r=%b en=%b%b exp w=%b r=%b", i, wr_ready, rd_ready, ram_wr_en, ram_rd_en, exp_w, !exp_w);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] v [4];
    int idx, nrsp;
    for (int k = 0; k < 4; k++) begin
      v[k] = 32'h5A5A_0000 + k;
      write_a(5'd20 + 5'(k), v[k], 32'hFFFFFFFF);
    end
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      rd_valid = (idx < 4); rd_addr = 5'd20 + 5'(idx);
      #1;
      if (rd_ready) idx++;
      @(negedge clk);
    end
    total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
    rd_valid = 1'b1; rd_addr = 5'd20 + 5'(idx);
    #1;
    total++; if (rd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_stalled got rd_ready=%b busy=%b exp=0/1", rd_ready, busy); end
    total++; if (rsp_valid !== 1'b1 || rsp_data !== v[0]) begin bad++; $display("FAIL bp_head got valid=%b data=%h exp=1/%h", rsp_valid, rsp_data, v[0]); end
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 5'd30; wr_data = 32'h55; wr_mask = 32'hFFFFFFFF;
    #1;
    total++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin bad++; $display("FAIL bp_write_passes got w=%b r=%b exp=1/0", wr_ready, rd_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 30 && nrsp < 4; c++) begin
      rd_valid = (idx < 4); rd_addr = 5'd20 + 5'(idx);
      #1;
      if (rsp_valid) begin
        total++;
        if (rsp_data !== v[nrsp]) begin bad++; $display("FAIL bp_rsp%0d got=%h exp=%h", nrsp, rsp_data, v[nrsp]); end
        nrsp++;
      end
      if (rd_ready) idx++;
      @(negedge clk);
    end
    rd_valid = 1'b0;
    total++; if (nrsp !== 4 || idx !== 4) begin bad++; $display("FAIL bp_totals got rsp=%0d acc=%0d exp=4/4", nrsp, idx); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mask();
    logic [DW-1:0] d;
    write_a(5'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    write_a(5'd3, 32'h00000000, 32'h0000FFFF);
    read_a(5'd3, d);
    total++; if (d !== 32'hFFFF0000) begin bad++; $display("FAIL mask_read got=%h exp=ffff0000", d); end
  endtask

  task automatic test_ram_reg0();
    z_rsp_ready = 1'b1;
    z_wr_valid = 1'b1; z_wr_addr = 5'd7; z_wr_data = 32'h12345678; z_wr_mask = 32'hFFFFFFFF;
    #1;
    total++; if (z_wr_ready !== 1'b1) begin bad++; $display("FAIL z_wr_ready got=%b exp=1", z_wr_ready); end
    @(negedge clk);
    z_wr_valid = 1'b0; z_rd_valid = 1'b1; z_rd_addr = 5'd7;
    #1;
    total++; if (z_rd_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin bad++; $display("FAIL z_rd_grant got rdy=%b rsp_valid=%b exp=1/0", z_rd_ready, z_rsp_valid); end
    @(negedge clk);
    z_rd_valid = 1'b0;
    #1;
    total++; if (z_rsp_valid !== 1'b1 || z_rsp_data !== 32'h12345678) begin bad++; $display("FAIL z_rsp got valid=%b data=%h exp=1/12345678", z_rsp_valid, z_rsp_data); end
    @(negedge clk);
    #1;
    total++; if (z_rsp_valid !== 1'b0 || z_busy !== 1'b0) begin bad++; $display("FAIL z_drained got valid=%b busy=%b exp=0/0", z_rsp_valid, z_busy); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    logic stale;
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 5'd20;
    #1;
    total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL mid_rd0 got=%b exp=1", rd_ready); end
    @(negedge clk);
    rd_addr = 5'd21;
    #1;
    total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL mid_rd1 got=%b exp=1", rd_ready); end
    @(negedge clk);
    rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 32'h77; wr_mask = 32'hFFFFFFFF;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL mid_wr got=%b exp=1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got busy=%b valid=%b exp=1/1", busy, rsp_valid); end
    reset = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_async_clear got valid=%b busy=%b exp=0/0", rsp_valid, busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rsp_valid !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL mid_stale_rsp got=%b exp=0", stale); end
    wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 32'h88; rd_valid = 1'b1; rd_addr = 5'd20;
    #1;
    total++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin bad++; $display("FAIL mid_prio_write got w=%b r=%b exp=1/0", wr_ready, rd_ready); end
    @(negedge clk);
    #1;
    total++; if (wr_ready !== 1'b0 || rd_ready !== 1'b1) begin bad++; $display("FAIL mid_prio_next got w=%b r=%b exp=0/1", wr_ready, rd_ready); end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b1;
    z_wr_valid = 1'b0; z_wr_addr = '0; z_wr_data = '0; z_wr_mask = '0; z_rd_valid = 1'b0; z_rd_addr = '0; z_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_alternate();
    test_backpressure();
    test_mask();
    test_ram_reg0();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
